wfa_bram_wr_arbiter: RTL
========================

Name: wfa_bram_wr_arbiter

Overview:
- Shares one BRAM write port (wen/din/addr) between NUM_REQ producer FIFOs, e.g. per-PE traceback FIFOs in the WFA aligner.
- Pops non-empty FIFOs round-robin and writes each word into that requester's private address region, at one write per cycle.
- Tracks per-region fill and overflow, and sequences start/flush so the traceback reader sees a completed, drained BRAM.

Parameters:
- NUM_REQ, 4: number of requester FIFOs; power of two, >= 2.
- DATA_WIDTH, 8: FIFO and BRAM word width.
- ADDR_WIDTH, 16: BRAM address width. OFF_BITS = ADDR_WIDTH - log2(NUM_REQ) is the per-region offset width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begin a session and clear all offsets and flags.
- flush  in  1  pulse; stop granting, drain, then signal done.
- fifo_empty  in  NUM_REQ  per-requester empty flag.
- fifo_dout  in  NUM_REQ*DATA_WIDTH  packed FIFO read data; requester i is at bits [i*DATA_WIDTH +: DATA_WIDTH]. Data is valid one cycle after fifo_ren.
- fifo_ren  out  NUM_REQ  one-hot-or-zero pop strobe.
- wen  out  1  BRAM write enable.
- din  out  DATA_WIDTH  BRAM write data.
- addr  out  ADDR_WIDTH  BRAM address = {req_id, offset}.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  single-cycle pulse when the flush completes.
- overflow  out  NUM_REQ  sticky; region i is full.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: all outputs 0, state IDLE, offsets 0, round-robin pointer 0. Asserting rst_n low mid-operation aborts immediately and discards any in-flight pop, so no wen is issued.
- States and transitions:
  - IDLE: start -> RUN; on entry to RUN, offsets and overflow flags are cleared. flush in IDLE is ignored.
  - RUN: arbitrates every cycle. flush -> DRAIN. start in RUN is ignored. start and flush together in IDLE: start wins and flush is ignored.
  - DRAIN: no new grants. One cycle after entry, the pipeline is empty; done pulses and the state returns to IDLE. busy deasserts in the same cycle that done is high.
- Eligibility: requester i is eligible when fifo_empty[i]=0 and overflow[i]=0.
- Arbitration: among eligible requesters, grant the first one at or after rr_ptr, wrapping modulo NUM_REQ. After a grant to g, rr_ptr = (g+1) mod NUM_REQ. With no eligible requester, there is no grant and rr_ptr holds.
- Pipeline, cycle t: fifo_ren[g]=1, and g is latched into stage-1 registers.
- Pipeline, cycle t+1: wen=1, din = fifo_dout slice of g, addr = {g, offset[g]}, then offset[g] increments. The write latency from pop is exactly 1 cycle. Sustained throughput is 1 write/cycle.
- Empty-flag timing: fifo_empty is sampled combinationally in cycle t. The FIFO is responsible for reflecting the pop at the next edge, so the same requester may be re-granted back-to-back if still non-empty.
- Overflow: when offset[g] = 2^OFF_BITS-1 is written, set overflow[g] in the same edge, and offset holds (no wrap). Region g is then masked until the next start. Other regions are unaffected.
- A flush arriving in the same cycle as a grant: the grant still issues, and its write completes in DRAIN before done.
- wen is 0 whenever there was no pop in the previous cycle. din and addr hold their last values when wen=0.

Optional Feature:
- Macro: WFA_WR_ARB_COUNT_EN.
- Defined: adds output wr_count (width ADDR_WIDTH+1), the total number of writes since the last start. It increments with each wen, is cleared on start entry, holds in IDLE, and resets to 0.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
All scenarios use NUM_REQ=4, DATA_WIDTH=8, ADDR_WIDTH=6 (OFF_BITS=4, region size 16).
- Reset: hold rst_n=0 with random inputs -> wen, fifo_ren, busy, done, overflow all 0. Release, pulse start -> busy=1 on the next cycle.
- Single requester: FIFO0 holds 0x11, 0x22, 0x33, others empty -> fifo_ren=0001 for 3 consecutive cycles. Writes are (addr 0x00, 0x11), (0x01, 0x22), (0x02, 0x33), each one cycle after its pop.
- Round-robin fairness: all four FIFOs non-empty (FIFO i holds 0xA0+i), rr_ptr=0.
  - Grant order is 0,1,2,3,0.
  - First-round addrs are 0x00, 0x10, 0x20, 0x30.
- Overflow: push 17 words into FIFO2.
  - The 16th write lands at addr 0x2F and sets overflow=0100.
  - The 17th word is never popped, and FIFO1 traffic continues normally.
- Flush with a pop in flight: flush is asserted in the same cycle as fifo_ren=0010.
  - The write to addr 0x10 still occurs.
  - done pulses the following cycle, then the state is IDLE with busy=0.
  - A start afterwards clears overflow, and the next FIFO0 write goes to addr 0x00.
- Reset mid-stream: deassert rst_n in the cycle after fifo_ren=0001 -> no wen is observed, and after release all offsets are 0. With WFA_WR_ARB_COUNT_EN defined, wr_count=0.

Source files
------------

// File: rtl/wfa_bram_wr_arbiter.sv
// Round-robin arbiter that shares one BRAM write port between NUM_REQ producer FIFOs.
// Optional macro WFA_WR_ARB_COUNT_EN adds wr_count, the number of writes since the last start.
module wfa_bram_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            fifo_empty,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] fifo_dout,
  output logic [NUM_REQ-1:0]            fifo_ren,
  output logic                          wen,
  output logic [DATA_WIDTH-1:0]         din,
  output logic [ADDR_WIDTH-1:0]         addr,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_REQ-1:0]            overflow
`ifdef WFA_WR_ARB_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]           wr_count
`endif
);

  localparam int ID_BITS  = $clog2(NUM_REQ);
  localparam int OFF_BITS = ADDR_WIDTH - ID_BITS;
  localparam logic [OFF_BITS-1:0] OFF_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state;
  logic [ID_BITS-1:0]    rr_ptr;
  logic [ID_BITS-1:0]    grant_id;
  logic                  grant_valid;
  logic [ID_BITS-1:0]    s1_id;
  logic                  s1_valid;
  logic [OFF_BITS-1:0]   offset [NUM_REQ];
  logic [NUM_REQ-1:0]    eligible;
  logic [DATA_WIDTH-1:0] dout_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] din_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  // A region whose last free slot is being written this cycle is masked already,
  // so no word is popped that could never be stored.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = !fifo_empty[i] && !overflow[i] &&
                    !(s1_valid && (s1_id == ID_BITS'(i)) && (offset[i] == OFF_MAX));
      dout_arr[i] = fifo_dout[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    logic [ID_BITS-1:0] idx;
    grant_valid = 1'b0;
    grant_id    = rr_ptr;
    idx         = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = rr_ptr + ID_BITS'(k);
      if ((state == RUN) && !grant_valid && eligible[idx]) begin
        grant_valid = 1'b1;
        grant_id    = idx;
      end
    end
  end

  always_comb begin
    fifo_ren = '0;
    if (grant_valid) fifo_ren[grant_id] = 1'b1;
  end

  // FIFO data arrives one cycle after the pop, so the write path is combinational from stage 1.
  assign wen  = s1_valid;
  assign din  = s1_valid ? dout_arr[s1_id] : din_q;
  assign addr = s1_valid ? {s1_id, offset[s1_id]} : addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rr_ptr   <= '0;
      s1_valid <= 1'b0;
      s1_id    <= '0;
      din_q    <= '0;
      addr_q   <= '0;
      overflow <= '0;
      for (int i = 0; i < NUM_REQ; i++) offset[i] <= '0;
    end else begin
      done     <= 1'b0;
      s1_valid <= grant_valid;
      din_q    <= din;
      addr_q   <= addr;
      if (grant_valid) begin
        s1_id  <= grant_id;
        rr_ptr <= grant_id + ID_BITS'(1);
      end
      if (s1_valid) begin
        if (offset[s1_id] == OFF_MAX) overflow[s1_id] <= 1'b1;
        else offset[s1_id] <= offset[s1_id] + OFF_BITS'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            overflow <= '0;
            for (int i = 0; i < NUM_REQ; i++) offset[i] <= '0;
          end
        end
        RUN: begin
          if (flush) state <= DRAIN;
        end
        DRAIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WFA_WR_ARB_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= '0;
    end else if ((state == IDLE) && start) begin
      wr_count <= '0;
    end else if (s1_valid) begin
      wr_count <= wr_count + (ADDR_WIDTH+1)'(1);
    end
  end
`endif

endmodule
